pu_riscv_memreq_buffer: RTL and testbench
=========================================

// Module: pu_riscv_memreq_buffer
// PURPOSE
//  Request FIFO between the pipeline memory stage and the memory subsystem.
//  Queues CPU load/store/fetch requests and presents them in order on a show-ahead head.
//  Its head fields (req/adr/size/instruction) drive the misalignment, PMA and PMP checkers and the BIU.
//  A pipeline flush drops all queued requests.
// PARAMETERS
//  XLEN   64  address/data width
//  DEPTH  4   number of entries; power of two, >=2
// PORTS
//  clk_i          in   1     clock; all logic on posedge
//  rst_i          in   1     synchronous, active-high reset
//  clr_i          in   1     flush: discard all entries
//  req_i          in   1     push request
//  instruction_i  in   1     1=fetch, 0=data access
//  adr_i          in   XLEN  request address
//  size_i         in   3     access size (BYTE/HWORD/WORD/DWORD, BIU pkg encoding)
//  we_i           in   1     write enable
//  lock_i         in   1     locked (AMO) access
//  d_i            in   XLEN  write data
//  ready_o        out  1     buffer can accept a push this cycle
//  req_o          out  1     head entry valid
//  instruction_o  out  1     head fields, mirroring inputs
//  adr_o          out  XLEN
//  size_o         out  3
//  we_o           out  1
//  lock_o         out  1
//  d_o            out  XLEN
//  ack_i          in   1     consumer takes head (pop)
//  empty_o        out  1     no valid entries
//  full_o         out  1     count==DEPTH
// BEHAVIOUR
//  - Reset: count=0, rd/wr pointers=0, req_o=0, empty_o=1, full_o=0, ready_o=1.
//    Payload outputs are don't-care while req_o=0; the bench checks only req_o.
//  - push = req_i & ready_o; pop = ack_i & req_o; ack_i with req_o=0 is ignored.
//  - ready_o = ~full_o. It depends only on registered state, with no comb path from ack_i.
//  - Without bypass: an entry pushed in cycle N appears on the head in cycle N+1 (1-cycle latency).
//  - Head is show-ahead: fields are stable while req_o=1 and no pop occurs.
//  - Ordering: strict FIFO. Pointers are $clog2(DEPTH) bits and wrap naturally.
//  - Count is $clog2(DEPTH+1) bits.
//  - Simultaneous push+pop: count unchanged.
//    Legal at full only if ready_o was 1, so at full a push never occurs.
//  - req_i while full: ignored, no state change. A bench assertion flags it as a protocol error.
//  - clr_i: next cycle count=0, pointers=0, req_o=0.
//    clr_i wins over a same-cycle push or pop; the push is lost.
//  - rst_i mid-operation behaves identically to clr_i.
//    rst_i has priority over everything.
// CONFIGURATION
//  MEMREQ_BUFFER_BYPASS_EN defined:
//    - When the buffer is empty and req_i=1, the head outputs show the incoming request combinationally in the same cycle.
//    - If ack_i is also 1, the request passes through and is not stored.
//    - If ack_i=0, it is written and stays on the head next cycle.
//    - clr_i blocks the bypass.
//  MEMREQ_BUFFER_BYPASS_EN undefined:
//    - Head is driven only from storage; latency is exactly 1 cycle.
// STRUCTURE
//  - Size encodings BYTE/HWORD/WORD/DWORD come from peripheral_biu_verilog_pkg.
//  - Add to the shared package: typedef struct packed memreq_t {instruction, adr, size, we, lock, d}.
//  - Storage is one sub-module, pu_riscv_memreq_ram:
//    - DEPTH x $bits(memreq_t) register array
//    - 1 write port, 1 async read port, no reset on contents
//  - Pointer, count and flag logic stays in this module.
// TESTING
//  1. Reset, then push adr=0x1000 size=WORD, ack_i=0.
//     -> req_o=1 next cycle with adr_o=0x1000, size_o=WORD; empty_o=0.
//  2. Push 4 requests (adr 0x0,0x8,0x10,0x18), no ack.
//     -> full_o=1, ready_o=0; a 5th req_i is ignored.
//     -> Then ack every cycle pops 0x0,0x8,0x10,0x18 in order; empty_o=1 after the 4th.
//  3. Count=2, push+pop in the same cycle.
//     -> count stays 2; head advances to the 2nd entry; new entry appears after it.
//  4. Count=3, clr_i=1 with req_i=1 and ack_i=1.
//     -> next cycle req_o=0, empty_o=1; the pushed request never appears.
//  5. Wrap: 10 push/pop pairs with increasing adr.
//     -> output sequence matches input exactly across pointer wrap.
//  6. Bypass build: empty, req_i=1 adr=0x2004 with ack_i=1.
//     -> req_o=1 and adr_o=0x2004 in the same cycle; empty_o stays 1 next cycle.
//     Non-bypass build, same stimulus: -> req_o=0 that cycle.

Source files
------------

// File: rtl/peripheral_biu_verilog_pkg.sv
// Shared BIU definitions: access-size encodings and the memory request record
// queued between the pipeline memory stage and the bus interface.
package peripheral_biu_verilog_pkg;

    localparam int MEMREQ_XLEN = 64;

    localparam logic [2:0] BYTE  = 3'b000;
    localparam logic [2:0] HWORD = 3'b001;
    localparam logic [2:0] WORD  = 3'b010;
    localparam logic [2:0] DWORD = 3'b011;

    typedef struct packed {
        logic                   instruction;
        logic [MEMREQ_XLEN-1:0] adr;
        logic [2:0]             size;
        logic                   we;
        logic                   lock;
        logic [MEMREQ_XLEN-1:0] d;
    } memreq_t;

endpackage

// File: rtl/pu_riscv_memreq_ram.sv
// Request storage: DEPTH x memreq_t register array with one write port and
// one asynchronous read port. Contents are never reset.
module pu_riscv_memreq_ram
    import peripheral_biu_verilog_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  memreq_t       wdata_i,
    input  logic [AW-1:0] raddr_i,
    output memreq_t       rdata_o
);

    memreq_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pu_riscv_memreq_buffer.sv
// In-order request FIFO with a show-ahead head feeding the memory checkers and BIU.
// Define MEMREQ_BUFFER_BYPASS_EN to present an incoming request on an empty head in the same cycle.
module pu_riscv_memreq_buffer
    import peripheral_biu_verilog_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            req_i,
    input  logic            instruction_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic [2:0]      size_i,
    input  logic            we_i,
    input  logic            lock_i,
    input  logic [XLEN-1:0] d_i,
    output logic            ready_o,
    output logic            req_o,
    output logic            instruction_o,
    output logic [XLEN-1:0] adr_o,
    output logic [2:0]      size_o,
    output logic            we_o,
    output logic            lock_o,
    output logic [XLEN-1:0] d_o,
    input  logic            ack_i,
    output logic            empty_o,
    output logic            full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;

    memreq_t inReq, headReq, ramRdata;
    logic    full, empty, push, pop, storeEn, popStored;

    assign inReq.instruction = instruction_i;
    assign inReq.adr         = adr_i;
    assign inReq.size        = size_i;
    assign inReq.we          = we_i;
    assign inReq.lock        = lock_i;
    assign inReq.d           = d_i;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign ready_o = ~full;
    assign empty_o = empty;
    assign full_o  = full;

    assign push = req_i & ~full;
    assign pop  = ack_i & req_o;

`ifdef MEMREQ_BUFFER_BYPASS_EN
    logic bypass;

    // An acked bypass passes straight through and never occupies storage
    assign bypass    = empty & req_i & ~clr_i & ~rst_i;
    assign req_o     = ~empty | bypass;
    assign headReq   = empty ? inReq : ramRdata;
    assign storeEn   = push & ~(bypass & ack_i);
    assign popStored = pop & ~empty;
`else
    assign req_o     = ~empty;
    assign headReq   = ramRdata;
    assign storeEn   = push;
    assign popStored = pop;
`endif

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (clr_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (storeEn) wrPtr_d = wrPtr_q + AW'(1);
            if (popStored) rdPtr_d = rdPtr_q + AW'(1);
            count_d = count_q + CW'(storeEn) - CW'(popStored);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    pu_riscv_memreq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (storeEn & ~clr_i & ~rst_i),
        .waddr_i (wrPtr_q),
        .wdata_i (inReq),
        .raddr_i (rdPtr_q),
        .rdata_o (ramRdata)
    );

    assign instruction_o = headReq.instruction;
    assign adr_o         = headReq.adr;
    assign size_o        = headReq.size;
    assign we_o          = headReq.we;
    assign lock_o        = headReq.lock;
    assign d_o           = headReq.d;

endmodule

// File: tb/tb_pu_riscv_memreq_buffer.sv
// Self-checking bench for pu_riscv_memreq_buffer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pu_riscv_memreq_buffer;
    import peripheral_biu_verilog_pkg::*;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
`ifdef MEMREQ_BUFFER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            clr_i = 1'b0;
    logic            req_i = 1'b0;
    logic            instruction_i = 1'b0;
    logic [XLEN-1:0] adr_i = '0;
    logic [2:0]      size_i = '0;
    logic            we_i = 1'b0;
    logic            lock_i = 1'b0;
    logic [XLEN-1:0] d_i = '0;
    logic            ack_i = 1'b0;
    logic            ready_o, req_o, instruction_o, we_o, lock_o, empty_o, full_o;
    logic [XLEN-1:0] adr_o, d_o;
    logic [2:0]      size_o;

    int  nChecks = 0;
    int  nFails  = 0;
    bit  checkEn = 1'b0;
    memreq_t modelQ[$];

    pu_riscv_memreq_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clr_i         (clr_i),
        .req_i         (req_i),
        .instruction_i (instruction_i),
        .adr_i         (adr_i),
        .size_i        (size_i),
        .we_i          (we_i),
        .lock_i        (lock_i),
        .d_i           (d_i),
        .ready_o       (ready_o),
        .req_o         (req_o),
        .instruction_o (instruction_o),
        .adr_o         (adr_o),
        .size_o        (size_o),
        .we_o          (we_o),
        .lock_o        (lock_o),
        .d_o           (d_o),
        .ack_i         (ack_i),
        .empty_o       (empty_o),
        .full_o        (full_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic memreq_t currentInputs();
        memreq_t r;
        r.instruction = instruction_i;
        r.adr         = adr_i;
        r.size        = size_i;
        r.we          = we_i;
        r.lock        = lock_i;
        r.d           = d_i;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Side fields are derived from the address so every entry is distinguishable
    task automatic applyStimulus(input logic req, input logic [XLEN-1:0] adr, input logic [2:0] size,
                                 input logic ack, input logic clr, input logic rst);
        @(posedge clk_i);
        #1;
        req_i         = req;
        adr_i         = adr;
        size_i        = size;
        instruction_i = adr[4];
        we_i          = adr[3];
        lock_i        = adr[5];
        d_i           = ~adr;
        ack_i         = ack;
        clr_i         = clr;
        rst_i         = rst;
        @(negedge clk_i);
    endtask

    // Reference model: a plain queue of accepted requests
    always @(posedge clk_i) begin
        int sz;
        sz = modelQ.size();
        if (rst_i || clr_i) begin
            modelQ.delete();
        end else begin
            if (req_i && sz == DEPTH)
                $display("[TB] protocol error: req_i asserted while full, request dropped at %0t", $time);
            if (!(BYPASS && sz == 0 && req_i && ack_i)) begin
                if (ack_i && sz > 0) void'(modelQ.pop_front());
                if (req_i && sz < DEPTH) modelQ.push_back(currentInputs());
            end
        end
    end

    always @(negedge clk_i) begin
        int      sz;
        logic    expReq;
        memreq_t h;
        if (checkEn) begin
            sz     = modelQ.size();
            expReq = 1'b0;
            h      = '0;
            if (sz > 0) begin
                expReq = 1'b1;
                h      = modelQ[0];
            end else if (BYPASS && req_i && !clr_i && !rst_i) begin
                expReq = 1'b1;
                h      = currentInputs();
            end
            checkOutput("model req_o", XLEN'(req_o), XLEN'(expReq));
            checkOutput("model ready_o", XLEN'(ready_o), XLEN'(sz < DEPTH));
            checkOutput("model empty_o", XLEN'(empty_o), XLEN'(sz == 0));
            checkOutput("model full_o", XLEN'(full_o), XLEN'(sz == DEPTH));
            if (expReq) begin
                checkOutput("model adr_o", adr_o, h.adr);
                checkOutput("model size_o", XLEN'(size_o), XLEN'(h.size));
                checkOutput("model instruction_o", XLEN'(instruction_o), XLEN'(h.instruction));
                checkOutput("model we_o", XLEN'(we_o), XLEN'(h.we));
                checkOutput("model lock_o", XLEN'(lock_o), XLEN'(h.lock));
                checkOutput("model d_o", d_o, h.d);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(0, 64'h0, BYTE, 0, 0, 1);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkEn = 1'b1;
        checkOutput("reset req_o", XLEN'(req_o), 64'h0);
        checkOutput("reset empty_o", XLEN'(empty_o), 64'h1);
        checkOutput("reset full_o", XLEN'(full_o), 64'h0);
        checkOutput("reset ready_o", XLEN'(ready_o), 64'h1);

        // Single push appears on the head one cycle later
        applyStimulus(1, 64'h1000, WORD, 0, 0, 0);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t1 req_o", XLEN'(req_o), 64'h1);
        checkOutput("t1 adr_o", adr_o, 64'h1000);
        checkOutput("t1 size_o", XLEN'(size_o), XLEN'(WORD));
        checkOutput("t1 empty_o", XLEN'(empty_o), 64'h0);
        applyStimulus(0, 64'h0, BYTE, 1, 0, 0);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t1 drained", XLEN'(empty_o), 64'h1);

        // Fill to full, extra request ignored, then drain in order
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 64'(8 * i), DWORD, 0, 0, 0);
        applyStimulus(1, 64'h20, DWORD, 0, 0, 0);
        checkOutput("t2 full_o", XLEN'(full_o), 64'h1);
        checkOutput("t2 ready_o", XLEN'(ready_o), 64'h0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 64'h0, BYTE, 1, 0, 0);
            checkOutput("t2 pop order", adr_o, 64'(8 * i));
        end
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t2 empty_o", XLEN'(empty_o), 64'h1);

        // Simultaneous push and pop at count 2
        applyStimulus(1, 64'h100, HWORD, 0, 0, 0);
        applyStimulus(1, 64'h108, HWORD, 0, 0, 0);
        applyStimulus(1, 64'h110, HWORD, 1, 0, 0);
        checkOutput("t3 head before", adr_o, 64'h100);
        applyStimulus(0, 64'h0, BYTE, 1, 0, 0);
        checkOutput("t3 head advanced", adr_o, 64'h108);
        applyStimulus(0, 64'h0, BYTE, 1, 0, 0);
        checkOutput("t3 new entry", adr_o, 64'h110);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t3 empty_o", XLEN'(empty_o), 64'h1);

        // Flush beats a same-cycle push and pop
        for (int i = 0; i < 3; i++) applyStimulus(1, 64'(32'h200 + 8 * i), WORD, 0, 0, 0);
        applyStimulus(1, 64'h300, WORD, 1, 1, 0);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t4 req_o", XLEN'(req_o), 64'h0);
        checkOutput("t4 empty_o", XLEN'(empty_o), 64'h1);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t4 push lost", XLEN'(req_o), 64'h0);

        // Pointer wrap with continuous push/pop
        applyStimulus(1, 64'h400, DWORD, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 64'(32'h400 + 8 * (i + 1)), DWORD, 1, 0, 0);
            checkOutput("t5 wrap head", adr_o, 64'(32'h400 + 8 * i));
        end
        applyStimulus(0, 64'h0, BYTE, 1, 0, 0);
        checkOutput("t5 last", adr_o, 64'h450);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t5 empty_o", XLEN'(empty_o), 64'h1);

        // Mid-run reset clears the queue
        applyStimulus(1, 64'h500, BYTE, 0, 0, 0);
        applyStimulus(1, 64'h508, BYTE, 0, 0, 0);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 1);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("rst req_o", XLEN'(req_o), 64'h0);
        checkOutput("rst empty_o", XLEN'(empty_o), 64'h1);

        // Request into an empty buffer with ack in the same cycle
        applyStimulus(1, 64'h2004, WORD, 1, 0, 0);
`ifdef MEMREQ_BUFFER_BYPASS_EN
        checkOutput("t6 bypass req_o", XLEN'(req_o), 64'h1);
        checkOutput("t6 bypass adr_o", adr_o, 64'h2004);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t6 bypass empty_o", XLEN'(empty_o), 64'h1);
`else
        checkOutput("t6 req_o", XLEN'(req_o), 64'h0);
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("t6 stored req_o", XLEN'(req_o), 64'h1);
        checkOutput("t6 stored adr_o", adr_o, 64'h2004);
        applyStimulus(0, 64'h0, BYTE, 1, 0, 0);
`endif
        applyStimulus(0, 64'h0, BYTE, 0, 0, 0);
        checkOutput("final empty_o", XLEN'(empty_o), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
